counter_sequencer: RTL and testbench

//   Command-driven controller that sequences the 8-bit counter datapath in the
//   tt_um counter project.

---
 rtl/counter_pkg.sv | 26 ++
 rtl/counter_prescaler.sv | 34 +++
 rtl/counter_sequencer.sv | 122 ++++++++++++
 tb/tb_counter_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the counter sequencer.
package counter_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DIV_W_DEF = 8;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_LOAD     = 3'd1;
    localparam logic [2:0] OP_RUN_UP   = 3'd2;
    localparam logic [2:0] OP_RUN_DOWN = 3'd3;
    localparam logic [2:0] OP_FREE_RUN = 3'd4;
    localparam logic [2:0] OP_SET_DIV  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    // Opcodes above SET_DIV are reserved and reported as errors.
    function automatic logic op_illegal(input logic [2:0] op);
        return op > OP_SET_DIV;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Programmable rate divider: one tick every div+1 enabled cycles, restartable via clear.
module counter_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] pcnt_q;
    logic [DIV_W-1:0] pcnt_d;

    always_comb begin
        tick   = enable & (pcnt_q == div);
        pcnt_d = pcnt_q;
        if (clear) begin
            pcnt_d = '0;
        end else if (enable) begin
            pcnt_d = tick ? '0 : pcnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for the 8-bit counter datapath: load, targeted runs,
// free running and a programmable count rate.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             stop,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             dir_q, dir_d;
    logic             free_q, free_d;
    logic             err_q, err_d;

    logic accept;
    logic in_run;
    logic at_target;
    logic tick;

    assign cmd_ready = (state_q == ST_IDLE) & ~stop;
    assign accept    = cmd_valid & cmd_ready;
    assign in_run    = (state_q == ST_RUN);
    assign at_target = (cnt_value == target_q);

    // Held clear outside RUN so every run starts with a fresh prescale count.
    counter_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (~in_run),
        .enable (in_run),
        .div    (div_q),
        .tick   (tick)
    );

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        div_d    = div_q;
        dir_d    = dir_q;
        free_d   = free_q;
        err_d    = accept & op_illegal(cmd_op);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            target_d = cmd_arg;
                            state_d  = ST_LOAD;
                        end
                        OP_RUN_UP, OP_RUN_DOWN: begin
                            target_d = cmd_arg;
                            dir_d    = (cmd_op == OP_RUN_UP);
                            free_d   = 1'b0;
                            state_d  = ST_RUN;
                        end
                        OP_FREE_RUN: begin
                            dir_d   = cmd_arg[0];
                            free_d  = 1'b1;
                            state_d = ST_RUN;
                        end
                        OP_SET_DIV: div_d = DIV_W'(cmd_arg);
                        default: ;
                    endcase
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            ST_RUN: begin
                if (stop || (!free_q && at_target)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            div_q    <= '0;
            dir_q    <= 1'b0;
            free_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            div_q    <= div_d;
            dir_q    <= dir_d;
            free_q   <= free_d;
            err_q    <= err_d;
        end
    end

    // The target compare is combinational so the strobe drops the cycle the count arrives.
    assign cnt_en       = in_run & tick & ~stop & (free_q | ~at_target);
    assign cnt_up       = in_run & dir_q;
    assign cnt_load     = (state_q == ST_LOAD);
    assign cnt_load_val = cnt_load ? target_q : '0;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign err          = err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer with a behavioural counter datapath.
module tb_counter_sequencer;
    import counter_pkg::*;

    localparam int K_LOAD = 0;
    localparam int K_EN   = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_arg = 8'd0;
    logic       stop = 1'b0;
    logic [7:0] cnt_value = 8'd0;
    logic       cmd_ready, cnt_load, cnt_en, cnt_up, busy, done, err;
    logic [7:0] cnt_load_val;

    typedef struct {
        int          kind;
        logic [15:0] data;
        int          gap;
    } ev_t;

    ev_t        exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    bit         skip = 1'b0;
    logic [7:0] model_cnt = 8'd0;

    always #5 clk = ~clk;

    counter_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_arg      (cmd_arg),
        .stop         (stop),
        .cnt_value    (cnt_value),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .cnt_en       (cnt_en),
        .cnt_up       (cnt_up),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    // Counter register driven by the sequencer's strobes.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cnt_load) cnt_value <= cnt_load_val;
        else if (cnt_en) cnt_value <= cnt_up ? cnt_value + 8'd1 : cnt_value - 8'd1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", tag, obs, cyc);
        end
    endtask

    function automatic void push(input int k, input logic [15:0] d, input int g);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.gap  = g;
        exp_q.push_back(e);
    endfunction

    // Expected strobes for a targeted run from model_cnt, then the done pulse.
    function automatic void push_run(input logic [7:0] t, input logic up, input int div);
        logic [7:0] v;
        v = model_cnt;
        while (v != t) begin
            push(K_EN, {7'b0, up, v}, div + 1);
            v = up ? v + 8'd1 : v - 8'd1;
        end
        push(K_DONE, {8'b0, t}, 2);
        model_cnt = t;
    endfunction

    task automatic observe(input int kind, input logic [15:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event_kind", 16'(kind), 16'hFFFF);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 16'(kind), 16'(e.kind));
            check("event_data", data, e.data);
            check("event_gap", 16'(cyc - last_cyc), 16'(e.gap));
            last_cyc = cyc;
        end
    endtask

    always @(negedge clk) begin
        if (!skip) begin
            if (cnt_load) observe(K_LOAD, {8'b0, cnt_load_val});
            if (cnt_en)   observe(K_EN, {7'b0, cnt_up, cnt_value});
            if (done)     observe(K_DONE, {8'b0, cnt_value});
            if (err)      observe(K_ERR, 16'h0000);
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] arg, input logic acc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        check("cmd_ready", 16'(cmd_ready), 16'(acc));
        #1;
        if (acc) last_cyc = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 8'd0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle", 16'(busy), 16'h0000);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", 16'({cmd_ready, busy, cnt_en, cnt_load, done, err, cnt_up}), 16'h0040);
        check("reset_load_val", 16'(cnt_load_val), 16'h0000);
        @(posedge clk);
        #1 rst = 1'b0;

        // LOAD 0x20
        push(K_LOAD, 16'h0020, 1);
        send(OP_LOAD, 8'h20, 1'b1);
        model_cnt = 8'h20;
        @(negedge clk);
        check("load_busy", 16'(busy), 16'h0001);
        @(negedge clk);
        check("after_load_flags", 16'({busy, cmd_ready}), 16'h0001);
        @(posedge clk);
        #1;

        // RUN_UP 0x20 -> 0x25 at full rate
        push_run(8'h25, 1'b1, 0);
        send(OP_RUN_UP, 8'h25, 1'b1);
        wait_idle();
        check("final_count_up", 16'(cnt_value), 16'(model_cnt));

        // SET_DIV 3, then RUN_DOWN 0x05 -> 0x02
        send(OP_SET_DIV, 8'h03, 1'b1);
        @(negedge clk);
        check("setdiv_no_busy", 16'(busy), 16'h0000);
        @(posedge clk);
        #1;
        push(K_LOAD, 16'h0005, 1);
        send(OP_LOAD, 8'h05, 1'b1);
        model_cnt = 8'h05;
        wait_idle();
        push_run(8'h02, 1'b0, 3);
        send(OP_RUN_DOWN, 8'h02, 1'b1);
        wait_idle();
        check("final_count_down", 16'(cnt_value), 16'(model_cnt));

        // FREE_RUN up through the wrap, commands while busy, then stop
        send(OP_SET_DIV, 8'h00, 1'b1);
        push(K_LOAD, 16'h00FE, 1);
        send(OP_LOAD, 8'hFE, 1'b1);
        wait_idle();
        push(K_EN, 16'h01FE, 1);
        push(K_EN, 16'h01FF, 1);
        push(K_EN, 16'h0100, 1);
        push(K_EN, 16'h0101, 1);
        push(K_DONE, 16'h0002, 2);
        send(OP_FREE_RUN, 8'h01, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_arg   = 8'h99;
        repeat (4) begin
            @(negedge clk);
            check("busy_not_ready", 16'(cmd_ready), 16'h0000);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        stop      = 1'b1;
        @(negedge clk);
        check("stop_cnt_en_low", 16'(cnt_en), 16'h0000);
        @(posedge clk);
        #1 stop = 1'b0;
        wait_idle();
        model_cnt = 8'h02;
        check("final_count_free", 16'(cnt_value), 16'(model_cnt));

        // Illegal opcode, zero-length run, command blocked by stop in IDLE
        push(K_ERR, 16'h0000, 1);
        send(3'd7, 8'h00, 1'b1);
        @(negedge clk);
        check("err_stays_idle", 16'(busy), 16'h0000);
        @(posedge clk);
        #1;
        push_run(8'h02, 1'b1, 0);
        send(OP_RUN_UP, 8'h02, 1'b1);
        wait_idle();
        stop = 1'b1;
        send(OP_LOAD, 8'h55, 1'b0);
        stop = 1'b0;
        @(negedge clk);
        check("stop_idle_no_accept", 16'(busy), 16'h0000);
        @(posedge clk);
        #1;

        // Reset in the middle of a slow run; div must also return to 0
        send(OP_SET_DIV, 8'h03, 1'b1);
        skip = 1'b1;
        send(OP_LOAD, 8'h00, 1'b1);
        wait_idle();
        send(OP_RUN_UP, 8'h80, 1'b1);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        skip = 1'b0;
        #1;
        check("rst_midrun_flags", 16'({cmd_ready, busy, cnt_en, cnt_load, done, err, cnt_up}), 16'h0040);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("after_rst_busy", 16'(busy), 16'h0000);
        @(posedge clk);
        #1;
        push(K_LOAD, 16'h0010, 1);
        send(OP_LOAD, 8'h10, 1'b1);
        model_cnt = 8'h10;
        wait_idle();
        push_run(8'h12, 1'b1, 0);
        send(OP_RUN_UP, 8'h12, 1'b1);
        wait_idle();

        repeat (3) @(posedge clk);
        check("queue_empty", 16'(exp_q.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
